// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Serializer for the UART transmit path. A parallel word is taken on a
// one-cycle data_valid strobe and sent on tx_out as an asynchronous frame:
// a start bit, the data bits LSB first, an optional parity bit and one stop
// bit. Bit timing comes from dividing UCLK by CLKS_PER_BIT.
//
// State table
//   state  | meaning
//   IDLE   | line high, waiting for data_valid
//   START  | driving the start bit (low)
//   DATA   | driving shift register bit 0, shifting at each bit boundary
//   PARITY | driving the parity value captured on entry
//   STOP   | driving the stop bit (high); tx_done on its last cycle
//
// Parameters
//   DATA_WIDTH    data bits per frame (5..9)
//   CLKS_PER_BIT  UCLK cycles per serial bit (>= 2)
//
// Ports
//   UCLK           in   block clock, rising edge
//   reset          in   asynchronous active-high reset
//   data_valid     in   one-cycle load strobe, accepted only while idle
//   parallel_data  in   word to transmit
//   parity_en      in   1 = insert a parity slot, sampled with data_valid
//   parity_bit     in   parity value from the upstream parity calculator
//   tx_out         out  serial line, idles high
//   busy           out  high while a frame is in progress
//   tx_done        out  one-cycle pulse in the first idle cycle after stop
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] parallel_data,
    input  logic                  parity_en,
    input  logic                  parity_bit,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_next;
    logic [BAUD_W-1:0]     baud_cnt, baud_cnt_next;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_reg_next;
    logic                  par_en_q, par_en_next;
    logic                  par_q, par_next;
    logic                  tx_out_next;
    logic                  busy_next;
    logic                  tx_done_next;
    logic                  bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_reg_next;
            par_en_q  <= par_en_next;
            par_q     <= par_next;
            tx_out    <= tx_out_next;
            busy      <= busy_next;
            tx_done   <= tx_done_next;
        end
    end

    always_comb begin
        state_next     = state;
        baud_cnt_next  = baud_cnt;
        bit_cnt_next   = bit_cnt;
        shift_reg_next = shift_reg;
        par_en_next    = par_en_q;
        par_next       = par_q;
        tx_done_next   = 1'b0;

        unique case (state)
            IDLE: begin
                if (data_valid) begin
                    shift_reg_next = parallel_data;
                    par_en_next    = parity_en;
                    baud_cnt_next  = '0;
                    bit_cnt_next   = '0;
                    state_next     = START;
                end
            end

            START: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_cnt_next  = '0;
                    shift_reg_next = shift_reg >> 1;
                    bit_cnt_next   = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_LAST) begin
                        if (par_en_q) begin
                            // Parity is captured only on entry so later
                            // movement on parity_bit cannot disturb the slot.
                            par_next   = parity_bit;
                            state_next = PARITY;
                        end else begin
                            state_next = STOP;
                        end
                    end
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_W'(1);
                end
            end

            PARITY: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    state_next    = STOP;
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_W'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    tx_done_next  = 1'b1;
                    state_next    = IDLE;
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next-state values and then registered, so
    // the line changes on the same edge as the state with no input-to-output
    // combinational path.
    always_comb begin
        tx_out_next = 1'b1;
        busy_next   = (state_next != IDLE);
        unique case (state_next)
            START:   tx_out_next = 1'b0;
            DATA:    tx_out_next = shift_reg_next[0];
            PARITY:  tx_out_next = par_next;
            default: tx_out_next = 1'b1;
        endcase
    end

endmodule
